// File: rtl/pe_link_fifo.sv
// Inter-PE link FIFO: first-word fall-through message buffer with registered
// occupancy, sticky overflow flag and synchronous flush.
module pe_link_fifo #(
    parameter int MSG_WIDTH = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [MSG_WIDTH-1:0] in_value,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [MSG_WIDTH-1:0] out_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] occupancy,
    output logic                 overflow_err
);

    localparam int                   PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    if (CNT_WIDTH != $clog2(DEPTH + 1)) begin : g_bad_cnt_width
        $error("pe_link_fifo: CNT_WIDTH must equal clog2(DEPTH+1)");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pe_link_fifo: DEPTH must be a power of two >= 2");
    end

    logic [MSG_WIDTH-1:0] mem_q [DEPTH];
    logic [MSG_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] occ_q, occ_d;
    logic                 ovf_q, ovf_d;
    logic                 push, pop;

    // Handshake flags come only from registered occupancy, so neither ready
    // nor valid has a combinational path from the opposite side.
    assign in_ready     = (occ_q < FULL_CNT);
    assign out_valid    = (occ_q != '0);
    assign out_value    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;

    // NOTE: every variable gets its default at the top of the always_comb;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q || (in_valid && !in_ready);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_value;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
                2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are masked because
    // out_value is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pe_link_fifo.sv
// Directed bench for pe_link_fifo: vector table plus streaming, wrap-around
// and asynchronous-reset sequences.
module tb_pe_link_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_value;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic        overflow_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_link_fifo #(.MSG_WIDTH(32), .DEPTH(4), .CNT_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_value     (in_value),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_value    (out_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] ival;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_val;
        logic [2:0]  e_occ;
        logic        e_ir;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] ival, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_value  = ival;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic fl, input logic iv, input logic [31:0] ival, input logic ordy,
                       input logic e_ov, input logic [31:0] e_val, input logic [2:0] e_occ,
                       input logic e_ir, input logic e_ovf);
        vec_t v;
        v.flush = fl; v.iv = iv; v.ival = ival; v.ordy = ordy;
        v.e_ov = e_ov; v.e_val = e_val; v.e_occ = e_occ; v.e_ir = e_ir; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic e_ov, input logic [31:0] e_val,
                                 input logic [2:0] e_occ, input logic e_ir, input logic e_ovf);
        check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, " out_value"}, out_value, e_val);
        check({tag, " occupancy"}, 32'(occupancy), 32'(e_occ));
        check({tag, " in_ready"}, 32'(in_ready), 32'(e_ir));
        check({tag, " overflow_err"}, 32'(overflow_err), 32'(e_ovf));
    endtask

    initial begin
        logic [31:0] model_q[$];
        logic [31:0] exp_word;
        int          sent;
        int          got;
        logic        ordy;

        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        check_outputs("reset_hold", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        //   flush iv  ival         ordy  ov  val          occ   ir    ovf
        add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      3'd0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'h0000_00A5, 1'b0, 1'b1, 32'hA5,  3'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      3'd0, 1'b1, 1'b0);
        // fill, overflow, drain
        add(1'b0, 1'b1, 32'd1,      1'b0, 1'b1, 32'd1,      3'd1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'd2,      1'b0, 1'b1, 32'd1,      3'd2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'd3,      1'b0, 1'b1, 32'd1,      3'd3, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'd4,      1'b0, 1'b1, 32'd1,      3'd4, 1'b0, 1'b0);
        add(1'b0, 1'b1, 32'd5,      1'b0, 1'b1, 32'd1,      3'd4, 1'b0, 1'b1);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'd2,      3'd3, 1'b1, 1'b1);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'd3,      3'd2, 1'b1, 1'b1);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'd4,      3'd1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      3'd0, 1'b1, 1'b1);
        // out_ready on empty is ignored
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      3'd0, 1'b1, 1'b1);
        // flush wins over a concurrent push and pop
        add(1'b0, 1'b1, 32'h9,      1'b0, 1'b1, 32'h9,      3'd1, 1'b1, 1'b1);
        add(1'b1, 1'b1, 32'hB,      1'b1, 1'b0, 32'h0,      3'd0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'hC,      1'b0, 1'b1, 32'hC,      3'd1, 1'b1, 1'b0);
        // full with simultaneous pop and push attempt
        add(1'b0, 1'b1, 32'h11,     1'b0, 1'b1, 32'hC,      3'd2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'h12,     1'b0, 1'b1, 32'hC,      3'd3, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'h13,     1'b0, 1'b1, 32'hC,      3'd4, 1'b0, 1'b0);
        add(1'b0, 1'b1, 32'h14,     1'b1, 1'b1, 32'h11,     3'd3, 1'b1, 1'b1);
        add(1'b0, 1'b1, 32'h15,     1'b1, 1'b1, 32'h12,     3'd3, 1'b1, 1'b1);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h13,     3'd2, 1'b1, 1'b1);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h15,     3'd1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      3'd0, 1'b1, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].iv, vecs[i].ival, vecs[i].ordy);
            step();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_val,
                          vecs[i].e_occ, vecs[i].e_ir, vecs[i].e_ovf);
        end

        // streaming: head always equals the word pushed on the last edge
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 32'h100 + 32'(k), 1'b1);
            step();
            check($sformatf("stream%0d out_value", k), out_value, 32'h100 + 32'(k));
            check($sformatf("stream%0d occupancy", k), 32'(occupancy), 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        check("stream_drain occupancy", 32'(occupancy), 32'd0);

        // wrap-around under random backpressure against a queue model
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 1000 && got < 40; cyc++) begin
            ordy = 1'($urandom_range(0, 1));
            drive(1'b0, sent < 40, 32'h200 + 32'(sent), ordy);
            check($sformatf("wrap%0d occupancy", cyc), 32'(occupancy), 32'(model_q.size()));
            check($sformatf("wrap%0d out_valid", cyc), 32'(out_valid), 32'(model_q.size() != 0));
            if (out_valid && ordy && model_q.size() != 0) begin
                exp_word = model_q.pop_front();
                check($sformatf("wrap_pop%0d", got), out_value, exp_word);
                got++;
            end
            if (in_valid && in_ready) begin
                model_q.push_back(in_value);
                sent++;
            end
            step();
        end
        check("wrap words received", 32'(got), 32'd40);
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        // asynchronous reset mid-transfer with overflow pending
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 32'h21 + 32'(k), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("pre_reset occupancy", 32'(occupancy), 32'd4);
        check("pre_reset overflow_err", 32'(overflow_err), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'h7, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check_outputs("post_reset push", 1'b1, 32'h7, 3'd1, 1'b1, 1'b0);
        step();
        check_outputs("post_reset pop", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
